// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - op codes, condition codes, FSM states and CC helper for the execute stage
package ex_pkg;

   typedef enum logic [3:0] {
      OP_ADD       = 4'd0,
      OP_ADDI      = 4'd1,
      OP_AND       = 4'd2,
      OP_ANDI      = 4'd3,
      OP_MOV       = 4'd4,
      OP_MOVI      = 4'd5,
      OP_CMP       = 4'd6,
      OP_CMPI      = 4'd7,
      OP_VADD      = 4'd8,
      OP_VMOV      = 4'd9,
      OP_VMOVI     = 4'd10,
      OP_VCOMPMOV  = 4'd11,
      OP_VCOMPMOVI = 4'd12
   } ex_op_e;

   localparam logic [2:0] CC_N = 3'b100;
   localparam logic [2:0] CC_Z = 3'b010;
   localparam logic [2:0] CC_P = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_VBUSY = 2'd1,
      S_OUT   = 2'd2
   } ex_state_e;

   // Caller supplies the sign bit and zero flag of the signed result.
   function automatic logic [2:0] cc_of(input logic i_neg, input logic i_zero);
      if (i_neg) return CC_N;
      if (i_zero) return CC_Z;
      return CC_P;
   endfunction

endpackage

// File: rtl/ex_vadd_lanes.sv
// rtl/ex_vadd_lanes.sv - LANES parallel wrapping element adders, purely combinational
module ex_vadd_lanes #(
   parameter int REG_WIDTH = 16,
   parameter int LANES     = 2
) (
   input  logic [LANES*REG_WIDTH-1:0] i_a,
   input  logic [LANES*REG_WIDTH-1:0] i_b,
   output logic [LANES*REG_WIDTH-1:0] o_sum
);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign o_sum[l*REG_WIDTH +: REG_WIDTH] = i_a[l*REG_WIDTH +: REG_WIDTH] + i_b[l*REG_WIDTH +: REG_WIDTH];
   end

endmodule

// File: rtl/ex_vector_exec.sv
// rtl/ex_vector_exec.sv - scalar/vector execute stage with lane-sliced VADD and stallable output register
module ex_vector_exec
   import ex_pkg::*;
#(
   parameter int REG_WIDTH     = 16,
   parameter int NUM_ELEMS     = 4,
   parameter int LANES         = 2,
   parameter int DEST_ID_WIDTH = 4
) (
   input  logic                           I_CLOCK,
   input  logic                           I_RESET_N,
   input  logic                           I_Valid,
   output logic                           O_Ready,
   input  logic [3:0]                     I_Op,
   input  logic [REG_WIDTH-1:0]           I_Src1,
   input  logic [REG_WIDTH-1:0]           I_Src2,
   input  logic [REG_WIDTH-1:0]           I_Imm,
   input  logic [REG_WIDTH*NUM_ELEMS-1:0] I_VecSrc1,
   input  logic [REG_WIDTH*NUM_ELEMS-1:0] I_VecSrc2,
   input  logic [$clog2(NUM_ELEMS)-1:0]   I_Idx,
   input  logic [DEST_ID_WIDTH-1:0]       I_DestIdx,
   input  logic                           I_Stall,
   output logic                           O_Valid,
   output logic [DEST_ID_WIDTH-1:0]       O_DestIdx,
   output logic [REG_WIDTH-1:0]           O_DestValue,
   output logic [REG_WIDTH*NUM_ELEMS-1:0] O_VecDestValue,
   output logic [2:0]                     O_CCValue,
   output logic                           O_RegWEn,
   output logic                           O_VRegWEn,
   output logic                           O_CCWEn
);

   localparam int BEATS     = NUM_ELEMS / LANES;
   localparam int LANE_BITS = LANES * REG_WIDTH;
   localparam int VEC_BITS  = NUM_ELEMS * REG_WIDTH;
   localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W     = $clog2(NUM_ELEMS);

   ex_state_e              r_state, w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [VEC_BITS-1:0]    r_va, r_vb;
   logic                   r_valid, r_reg_wen, r_vreg_wen, r_cc_wen;
   logic [DEST_ID_WIDTH-1:0] r_dest;
   logic [REG_WIDTH-1:0]   r_dval;
   logic [VEC_BITS-1:0]    r_vec;
   logic [2:0]             r_cc;

   logic                   w_accept, w_multi, w_last;
   logic [LANE_BITS-1:0]   w_add_a, w_add_b, w_sum;
   logic [REG_WIDTH-1:0]   w_res, w_cc_src;
   logic [VEC_BITS-1:0]    w_vec;
   logic                   w_reg_wen, w_vreg_wen, w_cc_wen;
   logic [2:0]             w_cc;

   ex_vadd_lanes #(.REG_WIDTH(REG_WIDTH), .LANES(LANES)) u_vadd (
      .i_a   (w_add_a),
      .i_b   (w_add_b),
      .o_sum (w_sum)
   );

   // Beat 0 is summed straight from the inputs on accept; VBUSY feeds the latched slice at cnt.
   always_comb begin
      w_add_a = I_VecSrc1[LANE_BITS-1:0];
      w_add_b = I_VecSrc2[LANE_BITS-1:0];
      if (r_state == S_VBUSY) begin
         for (int b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b)) begin
               w_add_a = r_va[b*LANE_BITS +: LANE_BITS];
               w_add_b = r_vb[b*LANE_BITS +: LANE_BITS];
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      O_Ready     = I_RESET_N && (r_state != S_VBUSY) && !(r_valid && I_Stall);
      w_accept    = I_Valid && O_Ready;
      w_multi     = (BEATS > 1) && (I_Op == OP_VADD);
      w_last      = (r_cnt == CNT_W'(BEATS - 1));
      case (r_state)
         S_IDLE, S_OUT: begin
            if (w_accept)
               w_state_nxt = w_multi ? S_VBUSY : S_OUT;
            else if (r_state == S_OUT && !I_Stall)
               w_state_nxt = S_IDLE;
         end
         S_VBUSY: if (w_last) w_state_nxt = S_OUT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_res      = '0;
      w_cc_src   = '0;
      w_vec      = '0;
      w_reg_wen  = 1'b0;
      w_vreg_wen = 1'b0;
      w_cc_wen   = 1'b0;
      case (I_Op)
         OP_ADD:  begin w_res = I_Src1 + I_Src2; w_reg_wen = 1'b1; end
         OP_ADDI: begin w_res = I_Src1 + I_Imm;  w_reg_wen = 1'b1; end
         OP_AND:  begin w_res = I_Src1 & I_Src2; w_reg_wen = 1'b1; end
         OP_ANDI: begin w_res = I_Src1 & I_Imm;  w_reg_wen = 1'b1; end
         OP_MOV:  begin w_res = I_Src1;          w_reg_wen = 1'b1; end
         OP_MOVI: begin w_res = I_Imm;           w_reg_wen = 1'b1; end
         OP_CMP:  begin w_cc_src = I_Src1 - I_Src2; w_cc_wen = 1'b1; end
         OP_CMPI: begin w_cc_src = I_Src1 - I_Imm;  w_cc_wen = 1'b1; end
         OP_VADD: begin w_vec = VEC_BITS'(w_sum); w_vreg_wen = 1'b1; end
         OP_VMOV: begin w_vec = I_VecSrc1; w_vreg_wen = 1'b1; end
         OP_VMOVI: begin w_vec = {NUM_ELEMS{I_Imm}}; w_vreg_wen = 1'b1; end
         OP_VCOMPMOV, OP_VCOMPMOVI: begin
            w_vec = I_VecSrc1;
            for (int e = 0; e < NUM_ELEMS; e++) begin
               if (I_Idx == IDX_W'(e))
                  w_vec[e*REG_WIDTH +: REG_WIDTH] = (I_Op == OP_VCOMPMOV) ? I_Src1 : I_Imm;
            end
            w_vreg_wen = 1'b1;
         end
         default: ;
      endcase
      if (w_reg_wen) begin
         w_cc_src = w_res;
         w_cc_wen = 1'b1;
      end
      w_cc = w_cc_wen ? cc_of(w_cc_src[REG_WIDTH-1], w_cc_src == '0) : 3'b000;
   end

   always_ff @(posedge I_CLOCK) begin
      if (!I_RESET_N) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_va       <= '0;
         r_vb       <= '0;
         r_valid    <= 1'b0;
         r_dest     <= '0;
         r_dval     <= '0;
         r_vec      <= '0;
         r_cc       <= '0;
         r_reg_wen  <= 1'b0;
         r_vreg_wen <= 1'b0;
         r_cc_wen   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_valid    <= !w_multi;
            r_dest     <= I_DestIdx;
            r_dval     <= w_res;
            r_vec      <= w_vec;
            r_cc       <= w_cc;
            r_reg_wen  <= w_reg_wen;
            r_vreg_wen <= w_vreg_wen;
            r_cc_wen   <= w_cc_wen;
            r_va       <= I_VecSrc1;
            r_vb       <= I_VecSrc2;
            r_cnt      <= w_multi ? CNT_W'(1) : '0;
         end else if (r_state == S_VBUSY) begin
            for (int b = 0; b < BEATS; b++) begin
               if (r_cnt == CNT_W'(b))
                  r_vec[b*LANE_BITS +: LANE_BITS] <= w_sum;
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
               r_valid <= 1'b1;
               r_cnt   <= '0;
            end
         end else if (r_state == S_OUT && !I_Stall) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign O_Valid        = r_valid;
   assign O_DestIdx      = r_dest;
   assign O_DestValue    = r_dval;
   assign O_VecDestValue = r_vec;
   assign O_CCValue      = r_cc;
   assign O_RegWEn       = r_reg_wen;
   assign O_VRegWEn      = r_vreg_wen;
   assign O_CCWEn        = r_cc_wen;

endmodule

// File: tb/tb_ex_vector_exec.sv
// tb/tb_ex_vector_exec.sv - directed scoreboard bench for ex_vector_exec (16-bit, 4 elements, 2 lanes)
module tb_ex_vector_exec;
   import ex_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_valid, i_stall;
   logic [3:0]  i_op;
   logic [15:0] i_src1, i_src2, i_imm;
   logic [63:0] i_vsrc1, i_vsrc2;
   logic [1:0]  i_idx;
   logic [3:0]  i_dest;
   logic        o_ready, o_valid, o_reg_wen, o_vreg_wen, o_cc_wen;
   logic [3:0]  o_dest;
   logic [15:0] o_dval;
   logic [63:0] o_vec;
   logic [2:0]  o_cc;

   typedef struct {
      logic [3:0]  dest;
      logic [15:0] dval;
      logic [63:0] vec;
      logic [2:0]  cc;
      logic        rw, vw, cw, chk_dval;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   ex_vector_exec #(.REG_WIDTH(16), .NUM_ELEMS(4), .LANES(2), .DEST_ID_WIDTH(4)) dut (
      .I_CLOCK(clk), .I_RESET_N(rstn), .I_Valid(i_valid), .O_Ready(o_ready), .I_Op(i_op),
      .I_Src1(i_src1), .I_Src2(i_src2), .I_Imm(i_imm), .I_VecSrc1(i_vsrc1), .I_VecSrc2(i_vsrc2),
      .I_Idx(i_idx), .I_DestIdx(i_dest), .I_Stall(i_stall), .O_Valid(o_valid), .O_DestIdx(o_dest),
      .O_DestValue(o_dval), .O_VecDestValue(o_vec), .O_CCValue(o_cc), .O_RegWEn(o_reg_wen),
      .O_VRegWEn(o_vreg_wen), .O_CCWEn(o_cc_wen)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [15:0] s1, input logic [15:0] s2,
                        input logic [15:0] imm, input logic [63:0] v1, input logic [63:0] v2,
                        input logic [1:0] idx, input logic [3:0] dest);
      i_valid = 1'b1; i_op = op; i_src1 = s1; i_src2 = s2; i_imm = imm;
      i_vsrc1 = v1; i_vsrc2 = v2; i_idx = idx; i_dest = dest;
      #1;
   endtask

   task automatic push(input logic [3:0] dest, input logic [15:0] dval, input logic [63:0] vec,
                       input logic [2:0] cc, input logic rw, input logic vw, input logic cw,
                       input logic chk_dval);
      exp_t e;
      e.dest = dest; e.dval = dval; e.vec = vec; e.cc = cc;
      e.rw = rw; e.vw = vw; e.cw = cw; e.chk_dval = chk_dval;
      sb.push_back(e);
   endtask

   task automatic check_out(input string tag, input bit do_pop);
      exp_t e;
      if (sb.size() == 0) begin
         n_vec++;
         n_miss++;
         $error("FAIL %s: observed output with empty scoreboard expected a queued result", tag);
         return;
      end
      e = sb[0];
      if (do_pop) void'(sb.pop_front());
      check({tag, "_valid"}, 64'(o_valid), 64'(1'b1));
      check({tag, "_dest"}, 64'(o_dest), 64'(e.dest));
      check({tag, "_wens"}, 64'({o_reg_wen, o_vreg_wen, o_cc_wen}), 64'({e.rw, e.vw, e.cw}));
      if (e.cw) check({tag, "_cc"}, 64'(o_cc), 64'(e.cc));
      if (e.chk_dval) check({tag, "_dval"}, 64'(o_dval), 64'(e.dval));
      if (e.vw) check({tag, "_vec"}, o_vec, e.vec);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected run completion");
      $fatal(1, "timeout");
   end

   initial begin
      rstn = 1'b0; i_stall = 1'b0;
      drive(OP_ADDI, 16'h0001, 16'h0002, 16'h0003, 64'h1, 64'h2, 2'd0, 4'd9);
      tick();
      tick();
      check("rst_ready", 64'(o_ready), 64'(0));
      check("rst_outs", {o_valid, o_reg_wen, o_vreg_wen, o_cc_wen, o_cc, o_dest, o_dval} , 64'(0));
      check("rst_vec", o_vec, 64'(0));
      rstn = 1'b1; i_valid = 1'b0;
      #1;
      check("post_rst_ready", 64'(o_ready), 64'(1));
      tick();
      check("idle_valid", 64'(o_valid), 64'(0));

      // ADDI overflow into the sign bit
      drive(OP_ADDI, 16'h7FFF, 16'h0000, 16'h0001, 64'h0, 64'h0, 2'd0, 4'd3);
      push(4'd3, 16'h8000, 64'h0, CC_N, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check_out("addi", 1'b1);

      // back-to-back compares, then ANDI and an undefined op
      drive(OP_CMP, 16'd5, 16'd5, 16'h0000, 64'h0, 64'h0, 2'd0, 4'd1);
      push(4'd1, 16'h0000, 64'h0, CC_Z, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      check_out("cmp", 1'b1);
      drive(OP_CMPI, 16'hFFFD, 16'h0000, 16'h0002, 64'h0, 64'h0, 2'd0, 4'd2);
      push(4'd2, 16'h0000, 64'h0, CC_N, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      check_out("cmpi", 1'b1);
      drive(OP_ANDI, 16'hF0F0, 16'h0000, 16'h0FF0, 64'h0, 64'h0, 2'd0, 4'd4);
      push(4'd4, 16'h00F0, 64'h0, CC_P, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check_out("andi", 1'b1);
      drive(4'hF, 16'h1111, 16'h2222, 16'h3333, 64'h0, 64'h0, 2'd0, 4'd6);
      push(4'd6, 16'h0000, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_out("undef", 1'b1);
      i_valid = 1'b0;
      tick();
      check("drain_valid", 64'(o_valid), 64'(0));

      // two-beat VADD; inputs scrambled after accept to prove operands are latched
      drive(OP_VADD, 16'h0, 16'h0, 16'h0, 64'hFFFF_0003_0002_0001, 64'h0001_0001_0001_0001, 2'd0, 4'd5);
      push(4'd5, 16'h0000, 64'h0000_0004_0003_0002, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      check("vadd_ready_pre", 64'(o_ready), 64'(1));
      tick();
      i_valid = 1'b0; i_vsrc1 = 64'hDEAD_BEEF_CAFE_F00D; i_vsrc2 = 64'h1234_5678_9ABC_DEF0;
      #1;
      check("vadd_busy_ready", 64'(o_ready), 64'(0));
      check("vadd_busy_valid", 64'(o_valid), 64'(0));
      tick();
      check_out("vadd", 1'b1);
      check("vadd_done_ready", 64'(o_ready), 64'(1));
      tick();

      // VCOMPMOVI then a 3-cycle stall with a MOVI waiting
      drive(OP_VCOMPMOVI, 16'h0, 16'h0, 16'h00AA, 64'h0004_0003_0002_0001, 64'h0, 2'd2, 4'd8);
      push(4'd8, 16'h0000, 64'h0004_00AA_0002_0001, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      i_stall = 1'b1;
      drive(OP_MOVI, 16'h0, 16'h0, 16'h1234, 64'h0, 64'h0, 2'd0, 4'd7);
      for (int s = 0; s < 3; s++) begin
         check("stall_ready", 64'(o_ready), 64'(0));
         check_out("stall_hold", 1'b0);
         if (s < 2) tick();
         else begin
            @(posedge clk);
            @(negedge clk);
            #1;
         end
      end
      i_stall = 1'b0;
      #1;
      check("unstall_ready", 64'(o_ready), 64'(1));
      check_out("vcompmovi", 1'b1);
      push(4'd7, 16'h1234, 64'h0, CC_P, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check_out("movi", 1'b1);
      i_valid = 1'b0;
      tick();

      // reset during the second VADD beat discards the op
      drive(OP_VADD, 16'h0, 16'h0, 16'h0, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 2'd0, 4'd10);
      tick();
      i_valid = 1'b0; rstn = 1'b0;
      tick();
      check("vrst_valid", 64'(o_valid), 64'(0));
      check("vrst_ready", 64'(o_ready), 64'(0));
      rstn = 1'b1;
      tick();
      check("vrst_after_valid", 64'(o_valid), 64'(0));
      drive(OP_MOV, 16'h0000, 16'h0, 16'h0, 64'h0, 64'h0, 2'd0, 4'd2);
      push(4'd2, 16'h0000, 64'h0, CC_Z, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check_out("mov_after_rst", 1'b1);
      i_valid = 1'b0;
      tick();
      check("end_valid", 64'(o_valid), 64'(0));
      check("sb_empty", 64'(sb.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
